// File: rtl/mipi_csi_rx_pkg.sv
// Purpose : shared constants and helpers for the CSI-2 receive packet decoder.
// Contents: data-type codes, packet_type encoding, header ECC and DT mapping.
// Notes   : pure package, no state.
package mipi_csi_rx_pkg;

   // CSI-2 data-type codes (6-bit DT field of the header DI byte)
   localparam logic [5:0] DT_FS          = 6'h00;
   localparam logic [5:0] DT_FE          = 6'h01;
   localparam logic [5:0] DT_SHORT_LIMIT = 6'h10;  // DT below this is a short packet
   localparam logic [5:0] DT_RAW8        = 6'h2A;
   localparam logic [5:0] DT_RAW10       = 6'h2B;
   localparam logic [5:0] DT_RAW12       = 6'h2C;
   localparam logic [5:0] DT_RAW14       = 6'h2D;

   // packet_type_o encoding handed to the RAW depacker
   localparam logic [2:0] PT_NONE  = 3'd0;
   localparam logic [2:0] PT_RAW8  = 3'd2;
   localparam logic [2:0] PT_RAW10 = 3'd3;
   localparam logic [2:0] PT_RAW12 = 3'd4;
   localparam logic [2:0] PT_RAW14 = 3'd5;

   // CSI-2 Hamming ECC over the 24-bit header {WC[15:0], DI[7:0]}.
   // d[0] is DI bit 0, d[23] is WC bit 15. The two upper ECC bits are
   // always zero, so only six parity bits are produced here.
   function automatic logic [5:0] csi_header_ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^
             d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^
             d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^
             d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
      p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^
             d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
      p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^
             d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
      p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^
             d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
      return p;
   endfunction

   // Long-packet DT to depacker packet_type; PT_NONE for anything unsupported.
   function automatic logic [2:0] dt_to_ptype(input logic [5:0] dt);
      logic [2:0] pt;
      case (dt)
         DT_RAW8:  pt = PT_RAW8;
         DT_RAW10: pt = PT_RAW10;
         DT_RAW12: pt = PT_RAW12;
         DT_RAW14: pt = PT_RAW14;
         default:  pt = PT_NONE;
      endcase
      return pt;
   endfunction

endpackage

// File: rtl/mipi_csi_rx_packet_decoder_8b2lane.sv
// Purpose : parse CSI-2 packet headers from the 2-lane aligned byte stream,
//           check header ECC, forward long-packet payload of one VC, and turn
//           FS/FE short packets into pulses.
// Latency : 1 cycle, data_i at edge N is on data_o after edge N.
// Backpr. : none; the aligner cannot be stalled, the depacker must keep up.
// Ports   : clk_i/reset_n_i clock and async active-low reset;
//           data_valid_i/data_i aligned stream in ([7:0] = earlier byte);
//           output_valid_o/data_o payload out; packet_type_o/packet_length_o
//           descriptor of the last accepted long packet; frame_start_o,
//           frame_end_o, ecc_error_o, truncated_o one-cycle event pulses.
module mipi_csi_rx_packet_decoder_8b2lane
   import mipi_csi_rx_pkg::*;
#(
   parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        data_valid_i,
   input  logic [15:0] data_i,
   output logic        output_valid_o,
   output logic [15:0] data_o,
   output logic [2:0]  packet_type_o,
   output logic [15:0] packet_length_o,
   output logic        frame_start_o,
   output logic        frame_end_o,
   output logic        ecc_error_o,
   output logic        truncated_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HDR1    = 2'd1;
   localparam logic [1:0] ST_PAYLOAD = 2'd2;
   localparam logic [1:0] ST_DRAIN   = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        vld_prev_q, vld_prev_d;
   logic [7:0]  di_q, di_d;
   logic [7:0]  wc_lo_q, wc_lo_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic        output_valid_q, output_valid_d;
   logic [15:0] data_q, data_d;
   logic [2:0]  packet_type_q, packet_type_d;
   logic [15:0] packet_length_q, packet_length_d;
   logic        frame_start_q, frame_start_d;
   logic        frame_end_q, frame_end_d;
   logic        ecc_error_q, ecc_error_d;
   logic        truncated_q, truncated_d;

   // Header fields available while in HDR1 (second header word on data_i)
   logic [15:0] wc_full;
   logic [5:0]  ecc_calc;
   logic        ecc_ok;
   logic [5:0]  hdr_dt;
   logic [2:0]  hdr_ptype;
   logic [15:0] wc_words;

   always_comb begin
      wc_full   = {data_i[7:0], wc_lo_q};
      ecc_calc  = csi_header_ecc({wc_full, di_q});
      ecc_ok    = (data_i[15:8] == {2'b00, ecc_calc});
      hdr_dt    = di_q[5:0];
      hdr_ptype = dt_to_ptype(hdr_dt);
      // ceil(WC/2) without needing a 17-bit intermediate
      wc_words  = {1'b0, wc_full[15:1]} + {15'd0, wc_full[0]};
   end

   always_comb begin
      state_d         = state_q;
      vld_prev_d      = data_valid_i;
      di_d            = di_q;
      wc_lo_d         = wc_lo_q;
      word_cnt_d      = word_cnt_q;
      output_valid_d  = 1'b0;
      data_d          = data_q;
      packet_type_d   = packet_type_q;
      packet_length_d = packet_length_q;
      frame_start_d   = 1'b0;
      frame_end_d     = 1'b0;
      ecc_error_d     = 1'b0;
      truncated_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Only a rising data_valid_i starts a packet; this also keeps a
            // packet already in flight at reset release from being misparsed.
            if (data_valid_i && !vld_prev_q) begin
               di_d    = data_i[7:0];
               wc_lo_d = data_i[15:8];
               state_d = ST_HDR1;
            end
         end

         ST_HDR1: begin
            if (!data_valid_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
               if (!ecc_ok) begin
                  ecc_error_d = 1'b1;
               end else if (di_q[7:6] == VIRTUAL_CHANNEL) begin
                  if (hdr_dt < DT_SHORT_LIMIT) begin
                     frame_start_d = (hdr_dt == DT_FS);
                     frame_end_d   = (hdr_dt == DT_FE);
                  end else if (hdr_ptype == PT_NONE) begin
                     packet_type_d = PT_NONE;
                  end else begin
                     packet_type_d   = hdr_ptype;
                     packet_length_d = wc_full;
                     if (wc_full != 16'd0) begin
                        word_cnt_d = wc_words;
                        state_d    = ST_PAYLOAD;
                     end
                  end
               end
            end
         end

         ST_PAYLOAD: begin
            if (data_valid_i) begin
               output_valid_d = 1'b1;
               data_d         = data_i;
               word_cnt_d     = word_cnt_q - 16'd1;
               if (word_cnt_q == 16'd1) begin
                  state_d = ST_DRAIN;
               end
            end else begin
               truncated_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         default: begin  // ST_DRAIN: swallow CRC and anything trailing
            if (!data_valid_i) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q         <= ST_IDLE;
         vld_prev_q      <= 1'b1;  // require a low cycle before the first header
         di_q            <= 8'd0;
         wc_lo_q         <= 8'd0;
         word_cnt_q      <= 16'd0;
         output_valid_q  <= 1'b0;
         data_q          <= 16'd0;
         packet_type_q   <= PT_NONE;
         packet_length_q <= 16'd0;
         frame_start_q   <= 1'b0;
         frame_end_q     <= 1'b0;
         ecc_error_q     <= 1'b0;
         truncated_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         vld_prev_q      <= vld_prev_d;
         di_q            <= di_d;
         wc_lo_q         <= wc_lo_d;
         word_cnt_q      <= word_cnt_d;
         output_valid_q  <= output_valid_d;
         data_q          <= data_d;
         packet_type_q   <= packet_type_d;
         packet_length_q <= packet_length_d;
         frame_start_q   <= frame_start_d;
         frame_end_q     <= frame_end_d;
         ecc_error_q     <= ecc_error_d;
         truncated_q     <= truncated_d;
      end
   end

   assign output_valid_o  = output_valid_q;
   assign data_o          = data_q;
   assign packet_type_o   = packet_type_q;
   assign packet_length_o = packet_length_q;
   assign frame_start_o   = frame_start_q;
   assign frame_end_o     = frame_end_q;
   assign ecc_error_o     = ecc_error_q;
   assign truncated_o     = truncated_q;

endmodule
